// File: rtl/des_pkg.sv
// des_pkg: DES permutation, shift and S-box tables, weak-key halves and FSM state type
// shared by the iterative DES round engine.
package des_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int SH_T  [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int SHD_T [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Each box is stored row-major: entry = row*16 + column.
    localparam int SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    // A weak key has each PC1 half entirely zero or entirely one.
    localparam logic [1:28] WK_C0 = '0;
    localparam logic [1:28] WK_C1 = '1;

    function automatic logic [1:64] ip(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 0; i < 64; i++) y[i+1] = x[IP_T[i]];
        return y;
    endfunction

    function automatic logic [1:64] fp(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 0; i < 64; i++) y[i+1] = x[FP_T[i]];
        return y;
    endfunction

    function automatic logic [1:48] e_exp(input logic [1:32] x);
        logic [1:48] y;
        for (int i = 0; i < 48; i++) y[i+1] = x[E_T[i]];
        return y;
    endfunction

    function automatic logic [1:32] p_perm(input logic [1:32] x);
        logic [1:32] y;
        for (int i = 0; i < 32; i++) y[i+1] = x[P_T[i]];
        return y;
    endfunction

    function automatic logic [1:56] pc1(input logic [1:64] x);
        logic [1:56] y;
        for (int i = 0; i < 56; i++) y[i+1] = x[PC1_T[i]];
        return y;
    endfunction

    function automatic logic [1:48] pc2(input logic [1:56] x);
        logic [1:48] y;
        for (int i = 0; i < 48; i++) y[i+1] = x[PC2_T[i]];
        return y;
    endfunction

    function automatic logic [1:28] rot28(input logic [1:28] x, input logic dec, input logic [1:0] n);
        return dec ? (n == 2'd2 ? {x[27:28], x[1:26]} : n == 2'd1 ? {x[28], x[1:27]} : x)
                   : (n == 2'd2 ? {x[3:28], x[1:2]} : n == 2'd1 ? {x[2:28], x[1]} : x);
    endfunction

endpackage

// File: rtl/des_fround.sv
// des_fround: one combinational DES round -- key-half rotation, PC2 subkey,
// expansion, S-boxes, P permutation and Feistel swap.
module des_fround
    import des_pkg::*;
(
    input  logic [1:32] l,
    input  logic [1:32] r,
    input  logic [1:28] c,
    input  logic [1:28] d,
    input  logic        dec,
    input  logic [3:0]  idx,
    output logic [1:32] l_n,
    output logic [1:32] r_n,
    output logic [1:28] c_n,
    output logic [1:28] d_n
);

    logic [1:0]  sh;
    logic [1:48] x;
    logic [1:32] s;

    // Decrypt walks the schedule backwards by rotating right, so K16 comes first.
    assign sh  = dec ? 2'(SHD_T[idx]) : 2'(SH_T[idx]);
    assign c_n = rot28(c, dec, sh);
    assign d_n = rot28(d, dec, sh);
    assign x   = e_exp(r) ^ pc2({c_n, d_n});

    for (genvar g = 0; g < 8; g++) begin : g_sbox
        assign s[4*g+1 +: 4] = 4'(SBOX[g][{x[6*g+1], x[6*g+6], x[6*g+2 +: 4]}]);
    end

    assign l_n = r;
    assign r_n = l ^ p_perm(s);

endmodule

// File: rtl/des_round_iter.sv
// des_round_iter: iterative single-DES engine, RPC rounds per clock, valid/ready on both sides.
// Optional weak-key flag enabled by defining DES_WEAK_KEY_CHK_EN.
module des_round_iter
    import des_pkg::*;
#(
    parameter int RPC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mode,
    input  logic [1:64] key,
    input  logic [1:64] din,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:64] dout,
    output logic        weak_key
);

    localparam int NRUN = 16 / RPC;

    if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8 && RPC != 16) begin : g_bad_rpc
        $error("des_round_iter: RPC must be 1, 2, 4, 8 or 16");
    end

    state_t      state, state_n;
    logic [1:32] l, r;
    logic [1:28] c, d;
    logic [4:0]  rnd;
    logic        mode_q;
    logic        last;
    logic        acc;
    logic [1:64] lr0;
    logic [1:56] cd0;
    logic [1:32] lc [RPC+1];
    logic [1:32] rc [RPC+1];
    logic [1:28] cc [RPC+1];
    logic [1:28] dc [RPC+1];

    assign lr0  = ip(din);
    assign cd0  = pc1(key);
    assign last = rnd == 5'((NRUN - 1) * RPC);
    assign acc  = in_ready && in_valid;

    assign lc[0] = l;
    assign rc[0] = r;
    assign cc[0] = c;
    assign dc[0] = d;

    for (genvar k = 0; k < RPC; k++) begin : g_rnd
        des_fround u_fround (
            .l   (lc[k]),
            .r   (rc[k]),
            .c   (cc[k]),
            .d   (dc[k]),
            .dec (mode_q),
            .idx (rnd[3:0] + 4'(k)),
            .l_n (lc[k+1]),
            .r_n (rc[k+1]),
            .c_n (cc[k+1]),
            .d_n (dc[k+1])
        );
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        state_n   = state == IDLE ? (in_valid ? RUN : IDLE)
                  : state == RUN  ? (last ? DONE : RUN)
                  : (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            l      <= '0;
            r      <= '0;
            c      <= '0;
            d      <= '0;
            rnd    <= '0;
            mode_q <= 1'b0;
            dout   <= '0;
        end else begin
            state <= state_n;
            if (acc) begin
                {l, r} <= lr0;
                {c, d} <= cd0;
                mode_q <= mode;
                rnd    <= '0;
            end else if (state == RUN) begin
                l   <= lc[RPC];
                r   <= rc[RPC];
                c   <= cc[RPC];
                d   <= dc[RPC];
                rnd <= rnd + 5'(RPC);
                if (last) dout <= fp({rc[RPC], lc[RPC]});
            end
        end
    end

`ifdef DES_WEAK_KEY_CHK_EN
    logic weak_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) weak_q <= 1'b0;
        else if (acc) weak_q <= (cd0[1:28] == WK_C0 || cd0[1:28] == WK_C1) &&
                                (cd0[29:56] == WK_C0 || cd0[29:56] == WK_C1);
    end

    assign weak_key = weak_q && out_valid;
`else
    assign weak_key = 1'b0;
`endif

endmodule
